sram_delay_ctrl: RTL and testbench
==================================

# sram_delay_ctrl

Initiator-side controller for the dual-port audio delay SRAM (port 0 read/write, port 1 read-only).
- Accepts one audio sample per handshake and writes it to a circular buffer through port 0.
- In the same SRAM cycle, reads the sample written `delay` samples earlier through port 1 and returns it on a valid/ready output.
- Sits between the effect datapath (echo/delay stage) and the SRAM macro.
- Zero-fills the whole buffer after reset and on request, so no uninitialised data ever reaches the output.

## Interface
Parameters:
- DATA_WIDTH, 16, sample and SRAM word width
- ADDR_WIDTH, 14, SRAM address width; buffer depth is RAM_DEPTH = 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock, also drives SRAM clk0 and clk1
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_data  in  DATA_WIDTH  input sample
- delay  in  ADDR_WIDTH  delay in samples, sampled at input handshake
- clear_req  in  1  start buffer zero-fill; honoured only in IDLE
- out_valid  out  1  delayed sample valid
- out_ready  in  1  downstream accepts delayed sample
- out_data  out  DATA_WIDTH  delayed sample
- clearing  out  1  high while in CLEAR
- csb0, web0  out  1 each  SRAM port 0 chip select and write enable, both active-low
- addr0  out  ADDR_WIDTH  SRAM port 0 address
- din0  out  DATA_WIDTH  SRAM port 0 write data
- csb1  out  1  SRAM port 1 chip select, active-low
- addr1  out  ADDR_WIDTH  SRAM port 1 address
- dout1  in  DATA_WIDTH  SRAM port 1 read data

## Operation
- All outputs are registered.
- Reset values:
  - csb0=1, web0=1, csb1=1
  - addr0=0, addr1=0, din0=0
  - in_ready=0, out_valid=0, out_data=0
  - clearing=1, wr_ptr=0, clr_addr=0
  - state=CLEAR
- CLEAR:
  - Each cycle drive csb0=0, web0=0, addr0=clr_addr, din0=0, then increment clr_addr.
  - After the write of address RAM_DEPTH-1 is driven, go to IDLE and set clr_addr=0, wr_ptr=0.
  - in_ready=0 and csb1=1 throughout.
- IDLE:
  - in_ready=1 and SRAM selects are deasserted.
  - If clear_req=1, go to CLEAR. clear_req has priority over in_valid in the same cycle, and the sample is not accepted.
  - Else, on in_valid && in_ready:
    - latch in_data;
    - compute d_eff = (delay==0) ? 1 : delay;
    - compute rd_addr = (wr_ptr - d_eff) mod RAM_DEPTH;
    - drop in_ready and go to ACCESS.
- ACCESS (one cycle):
  - Port 0: csb0=0, web0=0, addr0=wr_ptr, din0=sample.
  - Port 1: csb1=0, addr1=rd_addr.
  - Go to WAIT.
- WAIT (one cycle):
  - Deassert csb0, web0 and csb1.
  - At the closing edge, capture dout1 into out_data, set out_valid=1, wr_ptr <= wr_ptr+1 (wraps RAM_DEPTH-1 -> 0), go to OUT.
- OUT:
  - Hold out_valid and out_data stable until out_ready=1.
  - On the accepting edge: out_valid=0, in_ready=1, go to IDLE.
- Because delay 0 is forced to 1, port 0 and port 1 never address the same word in the same cycle. Delay 1 returns the previous sample.
- A delay of N returns sample k-N. Samples older than the last clear read as 0.
- `delay` changes take effect only at the next input handshake.

## Timing
- The SRAM registers its inputs on the posedge that closes ACCESS, and its read data is valid after the following negedge. The controller samples dout1 on the posedge closing WAIT.
- Latency: with the input handshake on edge T, out_valid is high from edge T+2. Data out_data is valid at that same edge.
- Minimum period is 4 cycles per sample (IDLE, ACCESS, WAIT, OUT) with out_ready held at 1.
- CLEAR lasts exactly RAM_DEPTH cycles. in_ready rises on the edge after the last clear write.
- Asynchronous reset in any state immediately forces the reset values and restarts CLEAR. A write in flight may be dropped, which is acceptable because the buffer is refilled with zeros.
- in_ready and out_valid are never both 1.

## Test plan
Run with ADDR_WIDTH=4 (RAM_DEPTH=16) against the SRAM model.
- **Reset sweep:** release rst_n and observe the zero-fill.
  - Required: clearing=1 for 16 cycles; addresses 0..15 are written with 0 in order; then in_ready=1.
- **Basic delay:** delay=3; send samples 0x0001..0x0008 with out_ready=1.
  - Required outputs: 0, 0, 0, 0x0001, 0x0002 ... 0x0005.
  - Required: each out_valid appears 2 edges after its input handshake.
- **Wrap:** delay=15; send 40 samples with values i+1.
  - Required: output j equals j-14 for j≥15 and 0 for j<15.
  - Required: addr0 wraps 15 -> 0 with no glitch.
- **Delay 0:** delay=0; send 0x00AA, then 0x00BB.
  - Required outputs: 0x0000, then 0x00AA.
  - Required: addr0 != addr1 in every ACCESS cycle.
- **Backpressure:** hold out_ready=0 for 5 cycles in OUT.
  - Required: out_data is stable, in_ready=0, csb0=csb1=1.
  - Required: on release, the next sample is accepted normally.
- **clear_req and mid-operation reset:**
  - clear_req asserted in IDLE together with in_valid -> sample is not accepted, CLEAR runs, and subsequent outputs are 0 until refilled.
  - rst_n pulsed low during WAIT -> all outputs return to their reset values and CLEAR restarts.

Source files
------------

// File: rtl/sram_delay_ctrl_if.sv
// SRAM bus between the delay controller and a dual-port macro
// (port 0 read/write, port 1 read-only, all strobes active-low).
interface sram_delay_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
);
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;

    modport master (
        output csb0, web0, addr0, din0, csb1, addr1,
        input  dout1
    );

    modport slave (
        input  csb0, web0, addr0, din0, csb1, addr1,
        output dout1
    );
endinterface

// File: rtl/sram_delay_ctrl.sv
// Circular-buffer delay controller: writes one sample per handshake through
// port 0 and returns the sample written `delay` samples earlier via port 1.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_CLEAR  | zero-fill one word per cycle, clr_addr 0 .. RAM_DEPTH-1
// ST_IDLE   | in_ready high, waiting for a sample or a clear request
// ST_ACCESS | port 0 writes the new sample, port 1 reads the delayed one
// ST_WAIT   | SRAM read data settles; captured on the closing edge
// ST_OUT    | delayed sample held on out_data until out_ready
module sram_delay_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic                  clear_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  clearing,
    sram_delay_ctrl_if.master     sram
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_OUT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] d_eff;

    // Delay 0 is promoted to 1 so the two ports never hit the same word.
    assign d_eff = (delay == '0) ? ADDR_ONE : delay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            wr_ptr     <= '0;
            clr_addr   <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            clearing   <= 1'b1;
            sram.csb0  <= 1'b1;
            sram.web0  <= 1'b1;
            sram.addr0 <= '0;
            sram.din0  <= '0;
            sram.csb1  <= 1'b1;
            sram.addr1 <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    sram.csb0  <= 1'b0;
                    sram.web0  <= 1'b0;
                    sram.addr0 <= clr_addr;
                    sram.din0  <= '0;
                    sram.csb1  <= 1'b1;
                    in_ready   <= 1'b0;
                    if (clr_addr == ADDR_LAST) begin
                        state    <= ST_IDLE;
                        clr_addr <= '0;
                        wr_ptr   <= '0;
                        clearing <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_ONE;
                    end
                end

                ST_IDLE: begin
                    sram.csb0 <= 1'b1;
                    sram.web0 <= 1'b1;
                    sram.csb1 <= 1'b1;
                    if (clear_req) begin
                        state    <= ST_CLEAR;
                        clearing <= 1'b1;
                        in_ready <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        sram.csb0  <= 1'b0;
                        sram.web0  <= 1'b0;
                        sram.addr0 <= wr_ptr;
                        sram.din0  <= in_data;
                        sram.csb1  <= 1'b0;
                        sram.addr1 <= wr_ptr - d_eff;
                        state      <= ST_ACCESS;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    sram.csb0 <= 1'b1;
                    sram.web0 <= 1'b1;
                    sram.csb1 <= 1'b1;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    out_data  <= sram.dout1;
                    out_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + ADDR_ONE;
                    state     <= ST_OUT;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state    <= ST_CLEAR;
                    clr_addr <= '0;
                    clearing <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_delay_ctrl.sv
// Directed bench for sram_delay_ctrl with a 16-word SRAM model and an
// expected-sample queue fed from a reference copy of the buffer.
module tb_sram_delay_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] delay;
    logic          clear_req;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          clearing;

    sram_delay_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

    sram_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .delay     (delay),
        .clear_req (clear_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clearing  (clearing),
        .sram      (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: inputs registered on posedge, array access on the negedge.
    logic [DW-1:0] mem [DEPTH];
    logic          m_csb0, m_web0, m_csb1;
    logic [AW-1:0] m_addr0, m_addr1;
    logic [DW-1:0] m_din0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEA0 | 16'(i);
        sif.dout1 = 16'hBEEF;
    end

    always @(posedge clk) begin
        m_csb0  <= sif.csb0;
        m_web0  <= sif.web0;
        m_addr0 <= sif.addr0;
        m_din0  <= sif.din0;
        m_csb1  <= sif.csb1;
        m_addr1 <= sif.addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0 && m_web0 === 1'b0) mem[m_addr0] <= m_din0;
        if (m_csb1 === 1'b0) sif.dout1 <= mem[m_addr1];
    end

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] ref_wr;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_wr, exp_rd;
    logic [DW-1:0] exp_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_wr = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 32'({clearing, in_ready, out_valid, sif.csb0, sif.web0, sif.csb1}), 32'h27);
        check({tag, "_addr"}, 32'({sif.addr0, sif.addr1}), 32'h0);
        check({tag, "_data"}, {sif.din0, out_data}, 32'h0);
    endtask

    // Called on the negedge where CLEAR is already visible.
    task automatic clear_sweep(input string tag);
        int   cnt;
        int   nw;
        logic ok;
        cnt = 0;
        nw  = 0;
        ok  = 1'b1;
        while (clearing === 1'b1 && cnt < 100) begin
            if (in_ready !== 1'b0 || sif.csb1 !== 1'b1) ok = 1'b0;
            if (sif.csb0 === 1'b0) begin
                if (sif.web0 !== 1'b0 || sif.addr0 !== AW'(nw) || sif.din0 !== '0) ok = 1'b0;
                nw++;
            end
            cnt++;
            @(negedge clk);
        end
        // the final zero write is still on the bus one cycle after clearing falls
        if (sif.csb0 === 1'b0) begin
            if (sif.web0 !== 1'b0 || sif.addr0 !== AW'(nw) || sif.din0 !== '0) ok = 1'b0;
            nw++;
        end
        check({tag, "_clr_cycles"}, 32'(cnt), 32'd16);
        check({tag, "_clr_writes"}, 32'(nw), 32'd16);
        check({tag, "_clr_order"}, 32'(ok), 32'd1);
        @(negedge clk);
        check({tag, "_ready_after_clr"}, 32'({in_ready, sif.csb0, sif.web0, clearing}), 32'he);
    endtask

    task automatic hs(input logic [DW-1:0] val, input logic [AW-1:0] dl);
        int            n;
        logic [AW-1:0] d;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = val;
        delay    = dl;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs_timeout", 32'(n < 100), 32'd1);
        d       = (dl == '0) ? AW'(1) : dl;
        exp_wr  = ref_wr;
        exp_rd  = ref_wr - d;
        exp_din = val;
        exp_q.push_back(ref_mem[exp_rd]);
        ref_mem[ref_wr] = val;
        ref_wr = ref_wr + AW'(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int            lat;
        logic [DW-1:0] exp_v;
        logic [DW-1:0] held;
        logic          ok;
        @(negedge clk);
        check("acc_strobes", 32'({sif.csb0, sif.web0, sif.csb1}), 32'h0);
        check("acc_addr0", 32'(sif.addr0), 32'(exp_wr));
        check("acc_addr1", 32'(sif.addr1), 32'(exp_rd));
        check("acc_din0", 32'(sif.din0), 32'(exp_din));
        check("acc_port_sep", 32'(sif.addr0 != sif.addr1), 32'd1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("out_latency_edges", 32'(lat - 1), 32'd2);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp_v = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(exp_v));
        end
        check("ready_vs_valid", 32'(in_ready), 32'd0);
        if (hold > 0) begin
            held = out_data;
            ok   = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                    sif.csb0 !== 1'b1 || sif.csb1 !== 1'b1) ok = 1'b0;
            end
            check("backpressure_hold", 32'(ok), 32'd1);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_release", 32'(out_valid), 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] val, input logic [AW-1:0] dl, input int hold);
        out_ready = (hold == 0);
        hs(val, dl);
        collect(hold);
    endtask

    task automatic do_clear(input logic with_valid);
        @(negedge clk);
        clear_req = 1'b1;
        in_valid  = with_valid;
        in_data   = 16'h1234;
        delay     = AW'(1);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("clr_req_no_accept", 32'({in_ready, sif.csb1, clearing}), 32'h3);
        model_clear();
        clear_sweep("req");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        delay     = '0;
        clear_req = 1'b0;
        out_ready = 1'b1;
        model_clear();

        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        clear_sweep("por");

        // delay 3: expect 0,0,0,1..5
        for (int i = 1; i <= 8; i++) send(DW'(i), AW'(3), 0);

        // clear wins over a simultaneous sample; old data reads back as 0
        do_clear(1'b1);
        for (int i = 0; i < 3; i++) send(16'h0100 + DW'(i), AW'(2), 0);

        do_clear(1'b0);
        for (int i = 0; i < 40; i++) send(DW'(i + 1), AW'(15), 0);

        do_clear(1'b0);
        send(16'h00AA, AW'(0), 0);
        send(16'h00BB, AW'(0), 0);

        send(16'h0055, AW'(2), 5);
        send(16'h0066, AW'(2), 0);

        // reset while in WAIT
        out_ready = 1'b1;
        hs(16'h0777, AW'(2));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        clear_sweep("mid");
        send(16'h0101, AW'(1), 0);
        send(16'h0202, AW'(1), 0);
        send(16'h0303, AW'(5), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
